// File: rtl/fetch_prefetch_unit_if.sv
// fetch_prefetch_unit_if: redirect, IRAM and decode-side bus of the fetch stage
interface fetch_prefetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
);
  logic                     redirect_valid;
  logic [31:0]              redirect_pc;
  logic                     imem_en;
  logic [ADDR_W-1:0]        imem_addr;
  logic [DATA_W-1:0]        imem_rdata;
  logic                     out_valid;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_instr;
  logic [31:0]              out_pc;
  logic [31:0]              out_next_pc;
  logic [$clog2(DEPTH):0]   occupancy;
  modport master (
    input  redirect_valid, redirect_pc, imem_rdata, out_ready,
    output imem_en, imem_addr, out_valid, out_instr, out_pc, out_next_pc, occupancy
  );
  modport slave (
    output redirect_valid, redirect_pc, imem_rdata, out_ready,
    input  imem_en, imem_addr, out_valid, out_instr, out_pc, out_next_pc, occupancy
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: PC owner, IRAM read issue and prefetch FIFO feeding decode
module fetch_prefetch_unit #(
  parameter int          ADDR_W   = 8,
  parameter int          DATA_W   = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input logic                    clock,
  input logic                    reset,
  fetch_prefetch_unit_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [31:0]       pcs_q   [DEPTH];
  logic [PW:0]       wr_q, rd_q, count;
  logic [PW+1:0]     level;
  logic [31:0]       pc_q, infl_pc_q, head_pc;
  logic              infl_q, pop;
  assign count             = wr_q - rd_q;
  assign bus.out_valid     = ~reset & (count != '0);
  assign pop               = bus.out_valid & bus.out_ready;
  // level counts buffered plus in-flight words after this cycle's pop; issue only if one slot is left
  assign level             = {1'b0, count} + {{(PW+1){1'b0}}, infl_q} - {{(PW+1){1'b0}}, pop};
  assign bus.imem_en       = ~reset & ~bus.redirect_valid & (level < (PW+2)'(DEPTH));
  assign bus.imem_addr     = pc_q[ADDR_W-1:0];
  assign head_pc           = pcs_q[rd_q[PW-1:0]];
  assign bus.out_instr     = bus.out_valid ? instr_q[rd_q[PW-1:0]] : '0;
  assign bus.out_pc        = bus.out_valid ? head_pc : '0;
  assign bus.out_next_pc   = bus.out_valid ? head_pc + 32'd1 : '0;
  assign bus.occupancy     = reset ? '0 : count;
  // pc, in-flight tag and FIFO pointers; redirect flushes everything except a same-cycle pop
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
    end else if (bus.redirect_valid) begin
      pc_q   <= bus.redirect_pc;
      infl_q <= 1'b0;
      wr_q   <= '0;
      rd_q   <= '0;
    end else begin
      infl_q <= bus.imem_en;
      if (bus.imem_en) begin
        pc_q      <= pc_q + 32'd1;
        infl_pc_q <= pc_q;
      end
      if (infl_q) wr_q <= wr_q + 1'b1;
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end
  // capture the IRAM word returned for last cycle's issue, tagged with its pc
  always_ff @(posedge clock) begin
    if (~reset & ~bus.redirect_valid & infl_q) begin
      instr_q[wr_q[PW-1:0]] <= bus.imem_rdata;
      pcs_q[wr_q[PW-1:0]]   <= infl_pc_q;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: scoreboard bench for the fetch stage, plus a RESET_PC=254 wrap instance
module tb_fetch_prefetch_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  always #5 clock = ~clock;
  fetch_prefetch_unit_if #(.ADDR_W(8), .DATA_W(32), .DEPTH(4)) ifa ();
  fetch_prefetch_unit_if #(.ADDR_W(8), .DATA_W(32), .DEPTH(4)) ifb ();
  fetch_prefetch_unit #(.ADDR_W(8), .DATA_W(32), .DEPTH(4), .RESET_PC(32'd0)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa.master));
  fetch_prefetch_unit #(.ADDR_W(8), .DATA_W(32), .DEPTH(4), .RESET_PC(32'd254)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb.master));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // synchronous IRAM models: word i holds 0x1000+i
  always @(posedge clock) if (ifa.imem_en) ifa.imem_rdata <= 32'h1000 + 32'(ifa.imem_addr);
  always @(posedge clock) if (ifb.imem_en) ifb.imem_rdata <= 32'h1000 + 32'(ifb.imem_addr);
  logic [63:0] qa[$];
  logic [31:0] exp_pc_a = 32'd0;
  bit          inf_a = 1'b0;
  // scoreboard A: queue holds in-flight + buffered words in issue order
  always @(negedge clock) begin : sb_a
    int fifo_n;
    bit pop, en;
    logic [63:0] e;
    if (reset) begin
      chk("rst_valid", 64'(ifa.out_valid), 64'd0);
      chk("rst_occ", 64'(ifa.occupancy), 64'd0);
      chk("rst_en", 64'(ifa.imem_en), 64'd0);
      chk("rst_instr", 64'(ifa.out_instr), 64'd0);
      chk("rst_pc", 64'(ifa.out_pc), 64'd0);
      chk("rst_npc", 64'(ifa.out_next_pc), 64'd0);
      qa.delete();
      exp_pc_a = 32'd0;
      inf_a = 1'b0;
    end else begin
      fifo_n = qa.size() - int'(inf_a);
      chk("occ", 64'(ifa.occupancy), 64'(fifo_n));
      chk("valid", 64'(ifa.out_valid), 64'(fifo_n > 0));
      pop = (fifo_n > 0) && ifa.out_ready;
      if (pop) begin
        e = qa.pop_front();
        chk("instr", 64'(ifa.out_instr), 64'(e[63:32]));
        chk("pc", 64'(ifa.out_pc), 64'(e[31:0]));
        chk("npc", 64'(ifa.out_next_pc), 64'(e[31:0] + 32'd1));
      end
      en = !ifa.redirect_valid && (qa.size() < 4);
      chk("en", 64'(ifa.imem_en), 64'(en));
      if (ifa.redirect_valid) begin
        qa.delete();
        exp_pc_a = ifa.redirect_pc;
        inf_a = 1'b0;
      end else begin
        if (en) begin
          chk("addr", 64'(ifa.imem_addr), 64'(exp_pc_a[7:0]));
          qa.push_back({32'h1000 + {24'h0, exp_pc_a[7:0]}, exp_pc_a});
          exp_pc_a++;
        end
        inf_a = en;
      end
    end
  end
  logic [31:0] qb[$];
  logic [31:0] exp_pc_b = 32'd254;
  bit          inf_b = 1'b0;
  // scoreboard B: always-ready stream from 254 across the 8-bit address wrap
  always @(negedge clock) begin : sb_b
    int fifo_n;
    logic [31:0] p;
    if (reset) begin
      qb.delete();
      exp_pc_b = 32'd254;
      inf_b = 1'b0;
    end else begin
      fifo_n = qb.size() - int'(inf_b);
      chk("b_valid", 64'(ifb.out_valid), 64'(fifo_n > 0));
      if (fifo_n > 0) begin
        p = qb.pop_front();
        chk("b_pc", 64'(ifb.out_pc), 64'(p));
        chk("b_npc", 64'(ifb.out_next_pc), 64'(p + 32'd1));
        chk("b_instr", 64'(ifb.out_instr), 64'(32'h1000 + {24'h0, p[7:0]}));
      end
      chk("b_en", 64'(ifb.imem_en), 64'd1);
      chk("b_addr", 64'(ifb.imem_addr), 64'(exp_pc_b[7:0]));
      qb.push_back(exp_pc_b);
      exp_pc_b++;
      inf_b = 1'b1;
    end
  end
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask
  initial begin
    ifa.redirect_valid = 1'b0;
    ifa.redirect_pc    = '0;
    ifa.out_ready      = 1'b1;
    ifb.redirect_valid = 1'b0;
    ifb.redirect_pc    = '0;
    ifb.out_ready      = 1'b1;
    do_reset();
    tick(2);
    chk("t1_first_valid", 64'(ifa.out_valid), 64'd1);
    chk("t1_first_instr", 64'(ifa.out_instr), 64'h1000);
    tick(10);
    do_reset();
    ifa.out_ready = 1'b0;
    tick(8);
    chk("t2_full_occ", 64'(ifa.occupancy), 64'd4);
    chk("t2_full_en", 64'(ifa.imem_en), 64'd0);
    chk("t2_head_pc", 64'(ifa.out_pc), 64'd0);
    ifa.out_ready = 1'b1;
    tick(10);
    ifa.out_ready = 1'b0;
    tick(6);
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 32'd100;
    tick();
    ifa.redirect_valid = 1'b0;
    ifa.out_ready      = 1'b1;
    chk("full_redir_occ", 64'(ifa.occupancy), 64'd0);
    tick(8);
    do_reset();
    for (int i = 0; i < 20 && !(ifa.out_valid && ifa.out_pc == 32'd5); i++) tick();
    chk("t3_reach_pc5", 64'(ifa.out_pc), 64'd5);
    ifa.redirect_valid = 1'b1;
    ifa.redirect_pc    = 32'd40;
    tick();
    ifa.redirect_valid = 1'b0;
    chk("t3_addr40", 64'(ifa.imem_addr), 64'd40);
    chk("t3_occ0", 64'(ifa.occupancy), 64'd0);
    chk("t4_no_stale", 64'(ifa.out_valid), 64'd0);
    tick(2);
    chk("t3_valid", 64'(ifa.out_valid), 64'd1);
    chk("t3_pc40", 64'(ifa.out_pc), 64'd40);
    tick(6);
    ifa.out_ready = 1'b0;
    for (int i = 0; i < 20 && ifa.occupancy != 3'd3; i++) tick();
    chk("t6_occ3", 64'(ifa.occupancy), 64'd3);
    reset = 1'b1;
    tick();
    chk("t6_valid0", 64'(ifa.out_valid), 64'd0);
    chk("t6_occ0", 64'(ifa.occupancy), 64'd0);
    reset = 1'b0;
    ifa.out_ready = 1'b1;
    chk("t6_restart_addr", 64'(ifa.imem_addr), 64'd0);
    tick(12);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
